fmr_fault_monitor: RTL

Sequential supervisor downstream of the five-modular-redundancy majority voter. Each cycle it takes the five replica bits and the voter's output Z. It tracks consecutive per-replica disagreements with Z and latches sticky fault flags for replicas that exceed a threshold. It also reports system health (normal / degraded / failed) and independently flags a voter whose Z is not the true majority of X.

---
 rtl/fmr_pkg.sv | 36 +++
 rtl/fmr_mismatch_ctr.sv | 70 +++++++
 rtl/fmr_fault_monitor.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fmr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fmr_pkg
//  Purpose  : Shared types and helpers for the five-modular-redundancy
//             fault monitor: replica count, health-state encoding,
//             5-input popcount and 5-input majority.
//  Revision : 1.0  initial release
// ============================================================================
package fmr_pkg;

    localparam int NREP = 5;

    // System health states, 2-bit encoded to match the state output
    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_FAILED   = 2'd2
    } fmr_state_t;

    // Number of set bits in a 5-bit vector (0..5)
    function automatic logic [2:0] popcount5(input logic [NREP-1:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < NREP; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

    // True majority of five replica bits
    function automatic logic maj5(input logic [NREP-1:0] v);
        return (popcount5(v) >= 3'd3);
    endfunction

endpackage : fmr_pkg
`default_nettype wire

// File: rtl/fmr_mismatch_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : fmr_mismatch_ctr
//  Purpose  : Consecutive-mismatch counter for one replica plus its sticky
//             fault flag. The counter saturates at 2^CW-1 and the flag is
//             set on the edge where the count reaches THRESH. Once faulty,
//             the counter is frozen. fault_nxt exposes the flag's next value
//             so the parent can keep its summary outputs in step with it.
//  Revision : 1.0  initial release
// ============================================================================
module fmr_mismatch_ctr #(
    parameter int THRESH = 4,
    parameter int CW     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic mismatch,
    output logic fault,
    output logic fault_nxt
);

    localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};
    localparam logic [CW-1:0] c_thresh  = CW'(THRESH);

    logic [CW-1:0] r_cnt;
    logic          r_fault;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_fault_nxt;

    // Saturating increment of the current run length
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

    // Next counter / flag: clear wins, faulty replicas freeze, a match breaks the run
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_fault_nxt = r_fault;
        if (clr) begin
            w_cnt_nxt   = '0;
            w_fault_nxt = 1'b0;
        end else if (en && !r_fault) begin
            if (mismatch) begin
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == c_thresh) begin
                    w_fault_nxt = 1'b1;
                end
            end else begin
                w_cnt_nxt = '0;
            end
        end
    end

    // Counter and sticky flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    assign fault     = r_fault;
    assign fault_nxt = w_fault_nxt;

endmodule : fmr_mismatch_ctr
`default_nettype wire

// File: rtl/fmr_fault_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : fmr_fault_monitor
//  Purpose  : Supervisor for a five-replica majority voter. Checks that the
//             voter output is the true majority, tracks per-replica
//             consecutive disagreement with the voter, latches sticky fault
//             flags and reports NORMAL / DEGRADED / FAILED health.
//  Revision : 1.0  initial release
// ============================================================================
module fmr_fault_monitor
    import fmr_pkg::*;
#(
    parameter int THRESH = 4,
    parameter int CW     = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [NREP-1:0] X,
    input  logic            Z,
    input  logic            clr_faults,
    output logic [NREP-1:0] fault_mask,
    output logic [2:0]      num_faulty,
    output logic [1:0]      state,
    output logic            alarm,
    output logic            voter_err
);

    logic            w_maj;
    logic            w_voter_bad;
    logic            w_trusted;
    logic [NREP-1:0] w_mismatch;
    logic [NREP-1:0] w_fault;
    logic [NREP-1:0] w_fault_nxt;
    logic [2:0]      w_nf_nxt;
    fmr_state_t      w_state_nxt;

    fmr_state_t      r_state;
    logic [2:0]      r_num_faulty;
    logic            r_alarm;
    logic            r_voter_err;

    // A sample whose Z disagrees with the true majority is not used for fault tracking
    assign w_maj       = maj5(X);
    assign w_voter_bad = in_valid && (Z != w_maj);
    assign w_trusted   = in_valid && !w_voter_bad;
    assign w_mismatch  = X ^ {NREP{Z}};

    generate
        for (genvar i = 0; i < NREP; i++) begin : g_rep
            fmr_mismatch_ctr #(
                .THRESH (THRESH),
                .CW     (CW)
            ) u_ctr (
                .clk       (clk),
                .rst       (rst),
                .clr       (clr_faults),
                .en        (w_trusted),
                .mismatch  (w_mismatch[i]),
                .fault     (w_fault[i]),
                .fault_nxt (w_fault_nxt[i])
            );
        end
    endgenerate

    // Health is judged on the fault mask that will be registered this edge
    assign w_nf_nxt = popcount5(w_fault_nxt);

    // Next health state: only escalates; clear is the only way back
    always_comb begin
        w_state_nxt = r_state;
        if (clr_faults) begin
            w_state_nxt = ST_NORMAL;
        end else begin
            case (r_state)
                ST_NORMAL: begin
                    if (w_nf_nxt >= 3'd3)       w_state_nxt = ST_FAILED;
                    else if (w_nf_nxt != 3'd0)  w_state_nxt = ST_DEGRADED;
                end
                ST_DEGRADED: begin
                    if (w_nf_nxt >= 3'd3)       w_state_nxt = ST_FAILED;
                end
                ST_FAILED: begin
                    w_state_nxt = ST_FAILED;
                end
                default: begin
                    w_state_nxt = ST_NORMAL;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Summary output registers, updated on the same edge as the fault flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num_faulty <= 3'd0;
            r_alarm      <= 1'b0;
        end else begin
            r_num_faulty <= w_nf_nxt;
            r_alarm      <= (w_state_nxt == ST_FAILED);
        end
    end

    // Sticky voter-error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_voter_err <= 1'b0;
        end else if (clr_faults) begin
            r_voter_err <= 1'b0;
        end else if (w_voter_bad) begin
            r_voter_err <= 1'b1;
        end
    end

    assign fault_mask = w_fault;
    assign num_faulty = r_num_faulty;
    assign state      = r_state;
    assign alarm      = r_alarm;
    assign voter_err  = r_voter_err;

endmodule : fmr_fault_monitor
`default_nettype wire
